pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/pe_feeder.sv | 132 +++++++++++++
 tb/tb_pe_feeder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic PE feeder: widths, init length and FSM encoding.
package systolic_pkg;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 8;
  localparam int PAIR_W   = 16;
  localparam int INIT_LEN = 2;
  localparam int INIT_W   = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ARM    = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Total operand pairs for one command; evaluated once when a command is latched.
  function automatic logic [PAIR_W-1:0] pair_count(input logic [CNT_W-1:0] len,
                                                   input logic [CNT_W-1:0] jobs);
    return PAIR_W'(len) * PAIR_W'(jobs);
  endfunction
endpackage

// File: rtl/pe_feeder.sv
// Feeds an operand-pair stream into a PE's A/B FIFOs for cfg_jobs dot products of
// cfg_len MACs each, then waits for every result strobe before signalling done.
module pe_feeder
  import systolic_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         cfg_len,
  input  logic [CNT_W-1:0]         cfg_jobs,
  input  logic                     cmd_start,
  input  logic                     cmd_abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     src_valid,
  output logic                     src_ready,
  input  logic signed [DATA_W-1:0] src_a,
  input  logic signed [DATA_W-1:0] src_b,
  output logic signed [DATA_W-1:0] a_in,
  output logic signed [DATA_W-1:0] b_in,
  output logic                     awe,
  output logic                     bwe,
  output logic                     ais,
  output logic                     bis,
  output logic                     start,
  output logic [CNT_W-1:0]         max_cntr,
  input  logic                     aff,
  input  logic                     bff,
  input  logic                     se,
  input  logic                     sat,
  output logic                     sat_seen
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, jobs_q;
  logic [PAIR_W-1:0]   pairs_left;
  logic [CNT_W-1:0]    results_seen, results_nxt;
  logic [INIT_W-1:0]   init_cnt;
  logic                aborting;

  logic cfg_bad, accept, active, abort, xfer, se_cnt, init_last, run_st, show_max;

  assign cfg_bad     = (cfg_len == '0) | (cfg_jobs == '0);
  assign accept      = (state_q == IDLE) & cmd_start & ~cfg_bad;
  assign active      = (state_q == INIT) | (state_q == ARM) | (state_q == STREAM) | (state_q == DRAIN);
  assign abort       = cmd_abort & active;
  assign run_st      = (state_q == STREAM) | (state_q == DRAIN);
  assign src_ready   = (state_q == STREAM) & ~aff & ~bff & (pairs_left != '0);
  // Abort wins over a same-cycle handshake so nothing lands in a FIFO being cleared.
  assign xfer        = src_valid & src_ready & ~cmd_abort;
  assign se_cnt      = se & run_st;
  assign results_nxt = results_seen + CNT_W'(se_cnt);
  assign init_last   = (init_cnt == INIT_W'(INIT_LEN - 1));
  assign show_max    = (state_q == ARM) | run_st | (state_q == DONE) | ((state_q == INIT) & aborting);

  assign awe  = xfer;
  assign bwe  = xfer;
  assign a_in = xfer ? src_a : '0;
  assign b_in = xfer ? src_b : '0;

  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    ais      = 1'b0;
    bis      = 1'b0;
    start    = 1'b0;
    max_cntr = show_max ? (len_q - CNT_W'(1)) : '0;
    unique case (state_q)
      IDLE: if (accept) state_d = INIT;
      INIT: begin
        ais = 1'b1;
        bis = 1'b1;
        if (init_last) state_d = aborting ? IDLE : ARM;
      end
      ARM: begin
        start   = 1'b1;
        state_d = STREAM;
      end
      STREAM: if (xfer && pairs_left == PAIR_W'(1)) state_d = DRAIN;
      DRAIN:  if (results_nxt == jobs_q) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = INIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      jobs_q       <= '0;
      pairs_left   <= '0;
      results_seen <= '0;
      init_cnt     <= '0;
      aborting     <= 1'b0;
      sat_seen     <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q <= state_d;
      err     <= (state_q == IDLE) & cmd_start & cfg_bad;

      if (accept) begin
        len_q        <= cfg_len;
        jobs_q       <= cfg_jobs;
        pairs_left   <= pair_count(cfg_len, cfg_jobs);
        results_seen <= '0;
        sat_seen     <= 1'b0;
        aborting     <= 1'b0;
      end else begin
        if (xfer)         pairs_left   <= pairs_left - PAIR_W'(1);
        if (se_cnt)       results_seen <= results_nxt;
        if (sat && run_st) sat_seen    <= 1'b1;
      end

      if (abort) begin
        aborting   <= 1'b1;
        pairs_left <= '0;
      end

      // Restart the clear window on every entry, including an abort landing mid-INIT.
      if (state_d == INIT && (state_q != INIT || abort))
        init_cnt <= '0;
      else if (state_q == INIT)
        init_cnt <= init_cnt + INIT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized scoreboard bench for pe_feeder: expected writes queued at command issue,
// popped and compared by an independent monitor.
module tb_pe_feeder;
  import systolic_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] cfg_len = '0, cfg_jobs = '0;
  logic cmd_start = 1'b0, cmd_abort = 1'b0;
  logic busy, done, err, src_ready;
  logic src_valid = 1'b0;
  logic signed [15:0] src_a = '0, src_b = '0;
  logic signed [15:0] a_in, b_in;
  logic awe, bwe, ais, bis, start, sat_seen;
  logic [7:0] max_cntr;
  logic aff = 1'b0, bff = 1'b0, se = 1'b0, sat = 1'b0;

  always #5 clk = ~clk;

  pe_feeder dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_jobs(cfg_jobs),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort), .busy(busy), .done(done), .err(err),
    .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
    .a_in(a_in), .b_in(b_in), .awe(awe), .bwe(bwe), .ais(ais), .bis(bis),
    .start(start), .max_cntr(max_cntr), .aff(aff), .bff(bff), .se(se), .sat(sat),
    .sat_seen(sat_seen)
  );

  typedef struct packed { logic [15:0] a; logic [15:0] b; } pair_t;

  pair_t exp_q[$];
  pair_t src_arr[$];
  int n_cmp = 0, n_bad = 0;
  int cmd_id = 0, exp_len = 1;
  bit src_en = 0, valid_rand = 0, stall_en = 0, aff_force = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, ais_cnt = 0, start_cnt = 0;
  int cyc = 0, last_ais_cyc = -10, start_cyc = 0;
  int base_wr, base_done, base_start, base_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops and protocol invariants, sampled on the falling edge.
  always @(negedge clk) begin
    pair_t p;
    cyc++;
    if (!rst) begin
      if (awe || bwe) chk("awe_eq_bwe", awe, bwe);
      if (awe) begin
        chk("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          chk("a_in", $unsigned(a_in), p.a);
          chk("b_in", $unsigned(b_in), p.b);
        end
        chk("max_cntr_stream", max_cntr, exp_len - 1);
        wr_cnt++;
      end else
        chk("data_zero_no_we", {a_in, b_in}, 0);
      if (aff || bff) chk("stall_no_write", awe, 0);
      if (cmd_abort && busy) chk("abort_no_write", awe, 0);
      if (!busy) chk("idle_max_cntr", max_cntr, 0);
      if (ais || bis) chk("ais_eq_bis", ais, bis);
      if (ais) begin ais_cnt++; last_ais_cyc = cyc; end
      if (start) begin start_cnt++; start_cyc = cyc; end
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  // Source / backpressure driver; follows the valid&ready handshake of the spec.
  always begin
    bit took;
    int drv_id, drv_idx;
    @(negedge clk);
    took = src_valid && src_ready && !cmd_abort && !rst;
    @(posedge clk); #2;
    if (cmd_id != drv_id) begin drv_id = cmd_id; drv_idx = 0; end
    else if (took) drv_idx++;
    if (src_en && drv_idx < src_arr.size()) begin
      src_valid = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_a = src_arr[drv_idx].a;
      src_b = src_arr[drv_idx].b;
    end else begin
      src_valid = 1'b0;
      src_a = 16'($urandom);
      src_b = 16'($urandom);
    end
    aff = aff_force | (stall_en && $urandom_range(0, 5) == 0);
    bff = stall_en && $urandom_range(0, 5) == 0;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {src_ready, awe, bwe, ais, bis, start, busy, done, err, sat_seen}, 0);
    chk({tag, "_max_cntr"}, max_cntr, 0);
    chk({tag, "_data"}, {a_in, b_in}, 0);
  endtask

  task automatic start_cmd(input int len, input int jobs);
    pair_t p;
    @(posedge clk); #1;
    base_wr = wr_cnt; base_done = done_cnt; base_start = start_cnt; base_err = err_cnt;
    cfg_len = 8'(len); cfg_jobs = 8'(jobs);
    if (len != 0 && jobs != 0) begin
      cmd_id++;
      src_arr.delete();
      exp_q.delete();
      exp_len = len;
      for (int i = 0; i < len * jobs; i++) begin
        p.a = 16'($urandom);
        p.b = 16'($urandom);
        src_arr.push_back(p);
        exp_q.push_back(p);
      end
    end
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (wr_cnt < n && t < 3000) begin @(negedge clk); #1; t++; end
    if (wr_cnt < n) chk("timeout_writes", wr_cnt, n);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 200) begin @(negedge clk); #1; t++; end
    if (done_cnt < n) chk("timeout_done", done_cnt, n);
  endtask

  task automatic pulse_se();
    @(posedge clk); #1 se = 1'b1;
    @(posedge clk); #1 se = 1'b0;
  endtask

  task automatic finish_cmd(input int len, input int jobs, input bit early_se);
    int nse = 0;
    src_en = 1;
    if (early_se) begin
      wait_wr(base_wr + len);
      pulse_se();
      nse = 1;
    end
    wait_wr(base_wr + len * jobs);
    for (int i = nse; i < jobs; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      pulse_se();
    end
    wait_done(base_done + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("total_writes", wr_cnt - base_wr, len * jobs);
    chk("done_count", done_cnt - base_done, 1);
    chk("start_count", start_cnt - base_start, 1);
    chk("start_after_init", start_cyc, last_ais_cyc + 1);
    chk("no_err", err_cnt - base_err, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
    src_en = 0;
  endtask

  initial begin
    int w0, a0, d0, e0, l, j;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, a0, d0, e0, l, j;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    // Basic 4x2 command, source always valid; a stray cmd_start mid-stream is ignored.
    valid_rand = 0; stall_en = 0;
    start_cmd(4, 2);
    src_en = 1;
    wait_wr(base_wr + 2);
    @(posedge clk); #1 cfg_len = 8'd0; cmd_start = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0;
    finish_cmd(4, 2, 0);

    // Five-cycle aff stall mid-stream.
    start_cmd(4, 2);
    src_en = 1;
    wait_wr(base_wr + 3);
    @(posedge clk); #1 aff_force = 1;
    w0 = wr_cnt;
    repeat (5) @(posedge clk);
    #1 aff_force = 0;
    chk("stall_writes", wr_cnt - w0, 0);
    finish_cmd(4, 2, 0);

    // Zero configs are rejected with a single err pulse.
    a0 = ais_cnt;
    start_cmd(0, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("err_len0", err_cnt - base_err, 1);
    chk("err_len0_busy", busy, 0);
    chk("err_len0_no_ais", ais_cnt - a0, 0);
    start_cmd(5, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_jobs0", err_cnt - base_err, 1);
    chk("err_jobs0_busy", busy, 0);

    // Abort after three writes.
    start_cmd(4, 2);
    src_en = 1;
    wait_wr(base_wr + 3);
    @(posedge clk); #1 cmd_abort = 1'b1;
    a0 = ais_cnt;
    @(posedge clk); #1 cmd_abort = 1'b0;
    src_en = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_ais_cycles", ais_cnt - a0, 2);
    chk("abort_writes", wr_cnt - base_wr, 3);
    chk("abort_no_done", done_cnt - base_done, 0);
    chk("abort_idle", busy, 0);

    // Reset mid-stream, then a minimal 1x1 command.
    start_cmd(4, 2);
    src_en = 1;
    wait_wr(base_wr + 2);
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #3 rst = 1'b1;
    #1 check_zero("rst_mid");
    src_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_err", err_cnt - e0, 0);
    start_cmd(1, 1);
    finish_cmd(1, 1, 0);

    // sat in DRAIN is sticky until the next command starts.
    start_cmd(3, 1);
    src_en = 1;
    wait_wr(base_wr + 3);
    @(posedge clk); #1 sat = 1'b1;
    @(posedge clk); #1 sat = 1'b0;
    chk("sat_set", sat_seen, 1);
    pulse_se();
    wait_done(base_done + 1);
    repeat (3) @(posedge clk);
    #1 chk("sat_hold_idle", sat_seen, 1);
    src_en = 0;
    start_cmd(2, 1);
    chk("sat_clear_init", sat_seen, 0);
    finish_cmd(2, 1, 0);

    // Randomized commands with random valid gaps and FIFO-full stalls.
    valid_rand = 1;
    for (int k = 0; k < 12; k++) begin
      l = $urandom_range(1, 6);
      j = $urandom_range(1, 4);
      stall_en = ($urandom_range(0, 1) == 1);
      start_cmd(l, j);
      finish_cmd(l, j, $urandom_range(0, 1) == 1);
    end
    stall_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
